lab_gate_ctrl: RTL and testbench

LAB_GATE_CTRL -- requirements
Module: lab_gate_ctrl

---
 rtl/lab_gate_ctrl_if.sv | 46 ++++
 rtl/lab_gate_ctrl.sv | 143 ++++++++++++++
 tb/tb_lab_gate_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/lab_gate_ctrl_if.sv
// Request/status bundle for the lab gate controller.
// Optional manual override input is present only when GATE_OVERRIDE_EN is defined.
interface lab_gate_ctrl_if;
    logic       entry_req;
    logic       exit_req;
`ifdef GATE_OVERRIDE_EN
    logic       override;
`endif
    logic       A;
    logic       B;
    logic [5:0] occupancy;
    logic       full;
    logic       empty;
    logic       busy;
    logic       deny;

    modport master (
        output entry_req,
        output exit_req,
`ifdef GATE_OVERRIDE_EN
        output override,
`endif
        input  A,
        input  B,
        input  occupancy,
        input  full,
        input  empty,
        input  busy,
        input  deny
    );

    modport slave (
        input  entry_req,
        input  exit_req,
`ifdef GATE_OVERRIDE_EN
        input  override,
`endif
        output A,
        output B,
        output occupancy,
        output full,
        output empty,
        output busy,
        output deny
    );
endinterface

// File: rtl/lab_gate_ctrl.sv
// Lab gate controller: admits/releases people, drives the door-lock AB flip-flop, tracks occupancy.
// Define GATE_OVERRIDE_EN to add the manual override input and the one-cycle TOGGLE state.
module lab_gate_ctrl #(
    parameter int unsigned MAX_OCC     = 30,
    parameter int unsigned OPEN_CYCLES = 8
) (
    input logic            clk,
    input logic            rst_n,
    lab_gate_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        SYNC,
        IDLE,
        OPEN_CMD,
        OPEN_WAIT,
        CLOSE_CMD
`ifdef GATE_OVERRIDE_EN
        ,
        TOGGLE
`endif
    } state_t;

    localparam logic [5:0] MAX_Q      = 6'(MAX_OCC);
    localparam logic [7:0] DWELL_LOAD = 8'(OPEN_CYCLES - 1);

    state_t     state;
    logic [5:0] occ;
    logic [7:0] timer;
    logic       dir_exit;
    logic       deny_q;
    logic       a_q;
    logic       b_q;
    logic       busy_q;
    logic       is_full;
    logic       is_empty;
    logic       deny_entry;
    logic       deny_exit;

    assign is_full    = (occ == MAX_Q);
    assign is_empty   = (occ == '0);
    assign deny_entry = bus.entry_req && !bus.exit_req && is_full;
    assign deny_exit  = bus.exit_req && !bus.entry_req && is_empty;

    // A/B/busy are registered alongside the state so they always equal the Moore decode of state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= SYNC;
            a_q      <= 1'b1;
            b_q      <= 1'b0;
            busy_q   <= 1'b1;
            occ      <= '0;
            timer    <= '0;
            deny_q   <= 1'b0;
            dir_exit <= 1'b0;
        end else begin
            deny_q <= 1'b0;
            unique case (state)
                SYNC: begin
                    state  <= IDLE;
                    a_q    <= 1'b0;
                    b_q    <= 1'b0;
                    busy_q <= 1'b0;
                end
                IDLE: begin
`ifdef GATE_OVERRIDE_EN
                    if (bus.override) begin
                        state  <= TOGGLE;
                        a_q    <= 1'b1;
                        b_q    <= 1'b1;
                        busy_q <= 1'b1;
                    end else
`endif
                    if (bus.exit_req && !is_empty) begin
                        state    <= OPEN_CMD;
                        dir_exit <= 1'b1;
                        a_q      <= 1'b0;
                        b_q      <= 1'b1;
                        busy_q   <= 1'b1;
                    end else if (bus.entry_req && !is_full) begin
                        state    <= OPEN_CMD;
                        dir_exit <= 1'b0;
                        a_q      <= 1'b0;
                        b_q      <= 1'b1;
                        busy_q   <= 1'b1;
                    end else if (deny_entry || deny_exit) begin
                        deny_q <= 1'b1;
                    end
                end
                OPEN_CMD: begin
                    state <= OPEN_WAIT;
                    timer <= DWELL_LOAD;
                    a_q   <= 1'b0;
                    b_q   <= 1'b0;
                end
                OPEN_WAIT: begin
                    if (timer == '0) begin
                        state <= CLOSE_CMD;
                        a_q   <= 1'b1;
                        b_q   <= 1'b0;
                    end else begin
                        timer <= timer - 8'd1;
                    end
                end
                CLOSE_CMD: begin
                    // Guards keep occupancy within 0..MAX_OCC even if the count were disturbed.
                    if (dir_exit) begin
                        if (!is_empty) occ <= occ - 6'd1;
                    end else begin
                        if (occ < MAX_Q) occ <= occ + 6'd1;
                    end
                    state  <= IDLE;
                    a_q    <= 1'b0;
                    b_q    <= 1'b0;
                    busy_q <= 1'b0;
                end
`ifdef GATE_OVERRIDE_EN
                TOGGLE: begin
                    state  <= IDLE;
                    a_q    <= 1'b0;
                    b_q    <= 1'b0;
                    busy_q <= 1'b0;
                end
`endif
                default: begin
                    state  <= SYNC;
                    a_q    <= 1'b1;
                    b_q    <= 1'b0;
                    busy_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.A         = a_q;
    assign bus.B         = b_q;
    assign bus.occupancy = occ;
    assign bus.full      = is_full;
    assign bus.empty     = is_empty;
    assign bus.busy      = busy_q;
    assign bus.deny      = deny_q;

endmodule

// File: tb/tb_lab_gate_ctrl.sv
// Self-checking bench for lab_gate_ctrl: directed scenarios plus random traffic against a
// transaction-level model (phase counter within an accepted request, occupancy as an int).
module tb_lab_gate_ctrl;

    localparam int unsigned MAX_OCC     = 2;
    localparam int unsigned OPEN_CYCLES = 3;
`ifdef GATE_OVERRIDE_EN
    localparam bit OV_ENABLED = 1'b1;
`else
    localparam bit OV_ENABLED = 1'b0;
`endif

    // Model phases: negative values are non-transaction states, 0..OPEN_CYCLES+1 are the
    // cycles since a request was accepted.
    localparam int PH_TOG  = -3;
    localparam int PH_SYNC = -2;
    localparam int PH_IDLE = -1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    lab_gate_ctrl_if bus();

    lab_gate_ctrl #(
        .MAX_OCC    (MAX_OCC),
        .OPEN_CYCLES(OPEN_CYCLES)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int m_phase   = PH_SYNC;
    int m_occ     = 0;
    bit m_dir_ex  = 1'b0;
    bit m_deny    = 1'b0;
    bit m_valid   = 1'b0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_update(input bit en, input bit ex, input bit rn, input bit ov);
        if (!rn) begin
            m_phase  = PH_SYNC;
            m_occ    = 0;
            m_deny   = 1'b0;
            m_dir_ex = 1'b0;
            m_valid  = 1'b1;
            return;
        end
        m_deny = 1'b0;
        if (m_phase == PH_SYNC || m_phase == PH_TOG) begin
            m_phase = PH_IDLE;
        end else if (m_phase == PH_IDLE) begin
            if (ov && OV_ENABLED) begin
                m_phase = PH_TOG;
            end else if (ex && m_occ > 0) begin
                m_phase  = 0;
                m_dir_ex = 1'b1;
            end else if (en && m_occ < int'(MAX_OCC)) begin
                m_phase  = 0;
                m_dir_ex = 1'b0;
            end else if ((en && !ex) || (ex && !en)) begin
                m_deny = 1'b1;
            end
        end else if (m_phase == int'(OPEN_CYCLES) + 1) begin
            m_occ   = m_dir_ex ? m_occ - 1 : m_occ + 1;
            m_phase = PH_IDLE;
        end else begin
            m_phase++;
        end
    endtask

    task automatic step(input bit en, input bit ex, input bit rn, input bit ov);
        @(negedge clk);
        if (m_valid) begin
            check_eq("A", int'(bus.A),
                     int'(m_phase == PH_SYNC || m_phase == PH_TOG || m_phase == int'(OPEN_CYCLES) + 1));
            check_eq("B", int'(bus.B), int'(m_phase == 0 || m_phase == PH_TOG));
            check_eq("busy", int'(bus.busy), int'(m_phase != PH_IDLE));
            check_eq("deny", int'(bus.deny), int'(m_deny));
            check_eq("occupancy", int'(bus.occupancy), m_occ);
            check_eq("full", int'(bus.full), int'(m_occ == int'(MAX_OCC)));
            check_eq("empty", int'(bus.empty), int'(m_occ == 0));
`ifndef GATE_OVERRIDE_EN
            check_eq("ab_never_11", int'(bus.A & bus.B), 0);
`endif
        end
        bus.entry_req = en;
        bus.exit_req  = ex;
        rst_n         = rn;
`ifdef GATE_OVERRIDE_EN
        bus.override  = ov;
`endif
        @(posedge clk);
        cyc++;
        model_update(en, ex, rn, ov);
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        bus.entry_req = 1'b0;
        bus.exit_req  = 1'b0;
`ifdef GATE_OVERRIDE_EN
        bus.override  = 1'b0;
`endif

        // Reset held for two edges, then released.
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        idle_steps(2);
        check_eq("post_reset_occ", int'(bus.occupancy), 0);

        // Single entry, then a second to reach full, then a denied third.
        step(1'b1, 1'b0, 1'b1, 1'b0);
        idle_steps(6);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        idle_steps(6);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        idle_steps(3);

        // One exit to occupancy 1, then simultaneous entry+exit: exit wins.
        step(1'b0, 1'b1, 1'b1, 1'b0);
        idle_steps(6);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        idle_steps(6);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        idle_steps(2);

        // Entry held through the whole transaction counts once.
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
        idle_steps(2);

        // Reset during the dwell aborts without an occupancy update.
        step(1'b1, 1'b0, 1'b1, 1'b0);
        idle_steps(2);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        idle_steps(3);

`ifdef GATE_OVERRIDE_EN
        step(1'b1, 1'b0, 1'b1, 1'b0);
        idle_steps(6);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        idle_steps(3);
`endif

        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 63) != 0, $urandom_range(0, 7) == 0);
        end
        idle_steps(8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
